// File: rtl/imem_loader.sv
// Byte-stream program loader: writes 16-bit words into instruction memory while holding the core.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // State entered once the last word is written (or straight after an empty length).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t      state, state_nxt;
  logic [7:0]  hi_byte;
  logic [15:0] len;
  logic [15:0] count;
  logic [15:0] count_inc;
  logic [15:0] len_next;
  logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer      = byte_valid && byte_ready;
  assign len_next  = {hi_byte, byte_data};
  assign count_inc = count + 16'd1;

  // NOTE: every output and next-state term gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (len_next == 16'd0)
            state_nxt = S_FINISH;
          else if ({1'b0, len_next} > 17'(DEPTH))
            state_nxt = S_ERROR;
          else
            state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = S_DATA_LO;
      end
      S_DATA_LO: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        imem_we   = 1'b1;
        state_nxt = (count_inc == len) ? S_FINISH : S_DATA_HI;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = (byte_data == csum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_nxt = S_LEN_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hi_byte    <= 8'd0;
      len        <= 16'd0;
      count      <= 16'd0;
      imem_addr  <= '0;
      imem_wdata <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            imem_addr <= '0;
            count     <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
          end
        end
        S_LEN_HI: if (xfer) hi_byte <= byte_data;
        S_LEN_LO: if (xfer) len <= len_next;
        S_DATA_HI: begin
          if (xfer) begin
            hi_byte <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= csum ^ byte_data;
`endif
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            imem_wdata <= {hi_byte, byte_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= csum ^ byte_data;
`endif
          end
        end
        S_WRITE: begin
          imem_addr <= imem_addr + ADDR_W'(1);
          count     <= count_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: scoreboard of expected memory writes plus status checks.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  xsum;

  imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("we_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check("we_addr", 32'(imem_addr), 32'(w.addr));
        check("we_data", 32'(imem_wdata), 32'(w.data));
      end
      mem[imem_addr] = imem_wdata;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
    int t;
    if (pulse_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (gap) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("byte_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    xsum = xsum ^ b;
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [15:0] w, input int gap, input bit pulse);
    wr_t e;
    e.addr = addr;
    e.data = w;
    sb.push_back(e);
    send_byte(w[15:8], gap, pulse);
    send_byte(w[7:0], gap, 1'b0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    xsum = 8'h00;
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_ready", 32'(byte_ready), 32'd1);
    check("start_clr_done", 32'({done, error}), 32'd0);
  endtask

  task automatic wait_end(input string tag, input logic exp_done);
    int t;
    t = 0;
    @(negedge clk);
    while (done !== 1'b1 && error !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check({tag, "_timeout"}, 32'(t), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] csum_local;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    xsum       = 8'h00;
    #12;
    check("rst_outputs", 32'({byte_ready, imem_we, cpu_hold, done, error}), 32'd0);
    check("rst_addr_data", {imem_addr, imem_wdata}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", 32'({byte_ready, imem_we, cpu_hold, done, error}), 32'd0);

    // Test 1: reset mid-stream after three words.
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h05, 0, 1'b0);
    send_word(8'd0, 16'h1111, 0, 1'b0);
    send_word(8'd1, 16'h2222, 0, 1'b0);
    send_word(8'd2, 16'h3333, 0, 1'b0);
    @(posedge clk); #1;
    check("t1_addr_before_rst", 32'(imem_addr), 32'd3);
    check("t1_hold_before_rst", 32'(cpu_hold), 32'd1);
    rst = 1'b1;
    #1;
    check("t1_rst_outputs", 32'({byte_ready, imem_we, cpu_hold, done, error}), 32'd0);
    check("t1_rst_addr_data", {imem_addr, imem_wdata}, 32'd0);
    check("t1_mem0", 32'(mem[0]), 32'h1111);
    check("t1_mem1", 32'(mem[1]), 32'h2222);
    check("t1_mem2", 32'(mem[2]), 32'h3333);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 2: two words, including strobe latency.
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_word(8'd0, 16'h1234, 0, 1'b0);
    check("t2_we_latency", 32'(imem_we), 32'd1);
    check("t2_ready_in_write", 32'(byte_ready), 32'd0);
    send_word(8'd1, 16'hABCD, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_local = xsum;
    send_byte(csum_local, 0, 1'b0);
`endif
    wait_end("t2", 1'b1);
    check("t2_addr_after", 32'(imem_addr), 32'd2);

    // Test 3: empty program.
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0, 1'b0);
`endif
    wait_end("t3", 1'b1);

    // Test 4: N = 257 exceeds depth.
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    wait_end("t4", 1'b0);

    // Boundary: N = 256 exactly fills memory (also restarts from ERROR).
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 256; i++)
      send_word(8'(i), 16'(i * 257) ^ 16'h5A3C, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_local = xsum;
    send_byte(csum_local, 0, 1'b0);
`endif
    wait_end("t_full", 1'b1);
    check("t_full_mem255", 32'(mem[255]), 32'(16'(255 * 257) ^ 16'h5A3C));

    // Test 5: test 2 stream with idle gaps and stray start pulses mid-load.
    do_start();
    send_byte(8'h00, 3, 1'b0);
    send_byte(8'h02, 0, 1'b1);
    send_word(8'd0, 16'h1234, $urandom_range(5, 0), 1'b1);
    send_word(8'd1, 16'hABCD, $urandom_range(5, 0), 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_local = xsum;
    send_byte(csum_local, 5, 1'b1);
`endif
    wait_end("t5", 1'b1);
    check("t5_addr_after", 32'(imem_addr), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 6: good and bad checksum for a single word.
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_word(8'd0, 16'h1234, 0, 1'b0);
    send_byte(8'h26, 0, 1'b0);
    wait_end("t6_good", 1'b1);
    mem[0] = 16'h0000;
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_word(8'd0, 16'h1234, 0, 1'b0);
    send_byte(8'h27, 0, 1'b0);
    wait_end("t6_bad", 1'b0);
    check("t6_bad_mem0", 32'(mem[0]), 32'h1234);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
